id_decode_stage: RTL and testbench

- Registered RV32I decode stage with a parametrised instruction queue and valid/ready handshakes on both sides.
- Sits between fetch and execute; absorbs fetch bursts while execute stalls.
- Emits a full decoded control bundle plus immediate and illegal-instruction flag.
- Adds flush support and optional M-extension decode.

---
 rtl/id_pkg.sv | 64 ++++++
 rtl/id_decode_comb.sv | 138 +++++++++++++
 rtl/id_decode_stage.sv | 128 ++++++++++++
 tb/tb_id_decode_stage.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_pkg.sv
// rtl/id_pkg.sv - RV32I decode constants and decoded-bundle type (M-extension codes used when ID_MEXT_EN is defined)
package id_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MEXT = 7'b0000001;

  localparam int ALU_W = 5;
  localparam logic [ALU_W-1:0] ALU_ADD = 5'd0;
  localparam logic [ALU_W-1:0] ALU_SUB = 5'd1;
  localparam logic [ALU_W-1:0] ALU_AND = 5'd3;
  localparam logic [ALU_W-1:0] ALU_OR  = 5'd4;
  localparam logic [ALU_W-1:0] ALU_XOR = 5'd5;
  localparam logic [ALU_W-1:0] ALU_SHL = 5'd6;
  localparam logic [ALU_W-1:0] ALU_SHR = 5'd7;
  localparam logic [ALU_W-1:0] ALU_SLT = 5'd8;
  localparam logic [ALU_W-1:0] ALU_LUI = 5'd9;
  localparam logic [ALU_W-1:0] ALU_BEQ = 5'd10;
  localparam logic [ALU_W-1:0] ALU_BNE = 5'd11;
  localparam logic [ALU_W-1:0] ALU_BGE = 5'd12;
  localparam logic [ALU_W-1:0] ALU_BLT = 5'd13;
  localparam logic [ALU_W-1:0] ALU_MUL = 5'd14;

  localparam logic [1:0] SIZE_WORD = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_BYTE = 2'd2;

  localparam logic [1:0] M2R_ALU = 2'd0;
  localparam logic [1:0] M2R_MEM = 2'd1;
  localparam logic [1:0] M2R_PC4 = 2'd2;

  localparam logic [1:0] JMP_NONE = 2'd0;
  localparam logic [1:0] JMP_JAL  = 2'd1;
  localparam logic [1:0] JMP_JALR = 2'd2;

  typedef struct packed {
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [4:0]       rd;
    logic [31:0]      imm;
    logic [ALU_W-1:0] alu_op;
    logic             alu_src;
    logic             mem_read;
    logic             mem_write;
    logic             reg_write;
    logic             branch;
    logic [1:0]       mem_to_reg;
    logic [1:0]       jump;
    logic [1:0]       inst_size;
    logic             is_signed;
    logic             illegal;
  } id_bundle_t;

endpackage

// File: rtl/id_decode_comb.sv
// rtl/id_decode_comb.sv - pure combinational RV32I decoder; M-extension decoded when ID_MEXT_EN is defined
module id_decode_comb
  import id_pkg::*;
(
  input  logic [31:0] inst,
  output id_bundle_t  dec
);

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        bad;

  assign opcode = inst[6:0];
  assign f3     = inst[14:12];
  assign f7     = inst[31:25];
  assign imm_i  = {{20{inst[31]}}, inst[31:20]};
  assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u  = {inst[31:12], 12'b0};
  assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  // Decode fields per opcode; any illegal encoding collapses to a bundle with only register indices and the illegal flag
  always_comb begin
    dec           = '0;
    dec.rs1       = inst[19:15];
    dec.rs2       = inst[24:20];
    dec.rd        = inst[11:7];
    dec.is_signed = 1'b1;
    bad           = 1'b0;
    if (inst[1:0] != 2'b11) begin
      bad = 1'b1;
    end else begin
      case (opcode)
        OPC_LUI: begin
          dec.imm = imm_u; dec.alu_op = ALU_LUI; dec.alu_src = 1'b1; dec.reg_write = 1'b1;
        end
        OPC_AUIPC: begin
          dec.imm = imm_u; dec.alu_op = ALU_ADD; dec.alu_src = 1'b1; dec.reg_write = 1'b1;
        end
        OPC_OP_IMM: begin
          dec.imm = imm_i; dec.alu_src = 1'b1; dec.reg_write = 1'b1;
          case (f3)
            3'b000: dec.alu_op = ALU_ADD;
            3'b001: begin dec.alu_op = ALU_SHL; if (f7 != F7_BASE) bad = 1'b1; end
            3'b010: dec.alu_op = ALU_SLT;
            3'b011: begin dec.alu_op = ALU_SLT; dec.is_signed = 1'b0; end
            3'b100: dec.alu_op = ALU_XOR;
            3'b101: begin
              dec.alu_op    = ALU_SHR;
              dec.is_signed = (f7 == F7_ALT);
              if (f7 != F7_BASE && f7 != F7_ALT) bad = 1'b1;
            end
            3'b110: dec.alu_op = ALU_OR;
            default: dec.alu_op = ALU_AND;
          endcase
        end
        OPC_LOAD: begin
          dec.imm = imm_i; dec.alu_op = ALU_ADD; dec.alu_src = 1'b1;
          dec.mem_read = 1'b1; dec.reg_write = 1'b1; dec.mem_to_reg = M2R_MEM;
          case (f3)
            3'b000: dec.inst_size = SIZE_BYTE;
            3'b001: dec.inst_size = SIZE_HALF;
            3'b010: dec.inst_size = SIZE_WORD;
            3'b100: begin dec.inst_size = SIZE_BYTE; dec.is_signed = 1'b0; end
            3'b101: begin dec.inst_size = SIZE_HALF; dec.is_signed = 1'b0; end
            default: bad = 1'b1;
          endcase
        end
        OPC_STORE: begin
          dec.imm = imm_s; dec.alu_op = ALU_ADD; dec.alu_src = 1'b1; dec.mem_write = 1'b1;
          case (f3)
            3'b000: dec.inst_size = SIZE_BYTE;
            3'b001: dec.inst_size = SIZE_HALF;
            3'b010: dec.inst_size = SIZE_WORD;
            default: bad = 1'b1;
          endcase
        end
        OPC_OP: begin
          dec.reg_write = 1'b1;
          if (f7 == F7_BASE) begin
            case (f3)
              3'b000: dec.alu_op = ALU_ADD;
              3'b001: dec.alu_op = ALU_SHL;
              3'b010: dec.alu_op = ALU_SLT;
              3'b011: begin dec.alu_op = ALU_SLT; dec.is_signed = 1'b0; end
              3'b100: dec.alu_op = ALU_XOR;
              3'b101: begin dec.alu_op = ALU_SHR; dec.is_signed = 1'b0; end
              3'b110: dec.alu_op = ALU_OR;
              default: dec.alu_op = ALU_AND;
            endcase
          end else if (f7 == F7_ALT && f3 == 3'b000) begin
            dec.alu_op = ALU_SUB;
          end else if (f7 == F7_ALT && f3 == 3'b101) begin
            dec.alu_op = ALU_SHR;
`ifdef ID_MEXT_EN
          end else if (f7 == F7_MEXT) begin
            dec.alu_op = ALU_MUL + {2'b00, f3};
`endif
          end else begin
            bad = 1'b1;
          end
        end
        OPC_BRANCH: begin
          dec.imm = imm_b; dec.branch = 1'b1;
          case (f3)
            3'b000: dec.alu_op = ALU_BEQ;
            3'b001: dec.alu_op = ALU_BNE;
            3'b100: dec.alu_op = ALU_BLT;
            3'b101: dec.alu_op = ALU_BGE;
            3'b110: begin dec.alu_op = ALU_BLT; dec.is_signed = 1'b0; end
            3'b111: begin dec.alu_op = ALU_BGE; dec.is_signed = 1'b0; end
            default: bad = 1'b1;
          endcase
        end
        OPC_JAL: begin
          dec.imm = imm_j; dec.alu_op = ALU_ADD; dec.alu_src = 1'b1; dec.reg_write = 1'b1;
          dec.mem_to_reg = M2R_PC4; dec.jump = JMP_JAL;
        end
        OPC_JALR: begin
          dec.imm = imm_i; dec.alu_op = ALU_ADD; dec.alu_src = 1'b1; dec.reg_write = 1'b1;
          dec.mem_to_reg = M2R_PC4; dec.jump = JMP_JALR;
          if (f3 != 3'b000) bad = 1'b1;
        end
        default: bad = 1'b1;
      endcase
    end
    if (bad) begin
      dec         = '0;
      dec.rs1     = inst[19:15];
      dec.rs2     = inst[24:20];
      dec.rd      = inst[11:7];
      dec.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/id_decode_stage.sv
// rtl/id_decode_stage.sv - registered RV32I decode stage with instruction queue and flush (ID_MEXT_EN enables M-extension)
module id_decode_stage
  import id_pkg::*;
#(
  parameter int PC_W     = 32,
  parameter int QDEPTH   = 2,
  parameter int ALU_OP_W = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                if_valid,
  output logic                if_ready,
  input  logic [31:0]         if_inst,
  input  logic [PC_W-1:0]     if_pc,
  output logic                id_valid,
  input  logic                id_ready,
  output logic [PC_W-1:0]     id_pc,
  output logic [4:0]          id_rs1,
  output logic [4:0]          id_rs2,
  output logic [4:0]          id_rd,
  output logic [31:0]         id_imm,
  output logic [ALU_OP_W-1:0] id_alu_op,
  output logic                id_alu_src,
  output logic                id_mem_read,
  output logic                id_mem_write,
  output logic                id_reg_write,
  output logic                id_branch,
  output logic [1:0]          id_mem_to_reg,
  output logic [1:0]          id_jump,
  output logic [1:0]          id_inst_size,
  output logic                id_is_signed,
  output logic                id_illegal
);

  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QDEPTH);

  logic [31:0]      q_inst [QDEPTH];
  logic [PC_W-1:0]  q_pc   [QDEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             q_empty, in_xfer, load, pop, bypass, push;
  logic [31:0]      src_inst;
  logic [PC_W-1:0]  src_pc;
  id_bundle_t       dec, out_q;
  logic [PC_W-1:0]  pc_q;

  // if_ready depends only on occupancy, never on id_ready
  assign q_empty  = (count == '0);
  assign if_ready = (count != FULL_CNT);
  assign in_xfer  = if_valid && if_ready;
  assign load     = !id_valid || id_ready;
  assign pop      = load && !q_empty;
  assign bypass   = load && q_empty && in_xfer;
  assign push     = in_xfer && !bypass;
  assign src_inst = q_empty ? if_inst : q_inst[rd_ptr];
  assign src_pc   = q_empty ? if_pc   : q_pc[rd_ptr];

  id_decode_comb u_decode (
    .inst (src_inst),
    .dec  (dec)
  );

  // Queue payload storage; contents are don't-care while unoccupied
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      q_inst[wr_ptr] <= if_inst;
      q_pc[wr_ptr]   <= if_pc;
    end
  end

  // Queue pointers and occupancy; flush discards everything including a same-cycle push
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  // Output register: refilled from queue head, else directly from fetch, else drained
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      id_valid <= 1'b0;
      out_q    <= '0;
      pc_q     <= '0;
    end else if (flush) begin
      id_valid <= 1'b0;
    end else if (load) begin
      if (pop || bypass) begin
        id_valid <= 1'b1;
        out_q    <= dec;
        pc_q     <= src_pc;
      end else begin
        id_valid <= 1'b0;
      end
    end
  end

  assign id_pc         = pc_q;
  assign id_rs1        = out_q.rs1;
  assign id_rs2        = out_q.rs2;
  assign id_rd         = out_q.rd;
  assign id_imm        = out_q.imm;
  assign id_alu_op     = ALU_OP_W'(out_q.alu_op);
  assign id_alu_src    = out_q.alu_src;
  assign id_mem_read   = out_q.mem_read;
  assign id_mem_write  = out_q.mem_write;
  assign id_reg_write  = out_q.reg_write;
  assign id_branch     = out_q.branch;
  assign id_mem_to_reg = out_q.mem_to_reg;
  assign id_jump       = out_q.jump;
  assign id_inst_size  = out_q.inst_size;
  assign id_is_signed  = out_q.is_signed;
  assign id_illegal    = out_q.illegal;

endmodule

// File: tb/tb_id_decode_stage.sv
// tb/tb_id_decode_stage.sv - scoreboard bench for id_decode_stage against a mnemonic-level RV32I model
module tb_id_decode_stage;

  localparam int QDEPTH = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        if_valid = 1'b0;
  logic        if_ready;
  logic [31:0] if_inst = '0;
  logic [31:0] if_pc = '0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_pc;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [31:0] id_imm;
  logic [4:0]  id_alu_op;
  logic        id_alu_src, id_mem_read, id_mem_write, id_reg_write, id_branch;
  logic [1:0]  id_mem_to_reg, id_jump, id_inst_size;
  logic        id_is_signed, id_illegal;

  id_decode_stage #(.PC_W(32), .QDEPTH(QDEPTH), .ALU_OP_W(5)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .if_valid(if_valid), .if_ready(if_ready), .if_inst(if_inst), .if_pc(if_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_imm(id_imm),
    .id_alu_op(id_alu_op), .id_alu_src(id_alu_src), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_reg_write(id_reg_write), .id_branch(id_branch),
    .id_mem_to_reg(id_mem_to_reg), .id_jump(id_jump), .id_inst_size(id_inst_size),
    .id_is_signed(id_is_signed), .id_illegal(id_illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic [4:0]  alu_op;
    logic        alu_src, mem_read, mem_write, reg_write, branch;
    logic [1:0]  mem_to_reg, jump, size;
    logic        is_signed, illegal;
  } exp_t;

  int checks = 0;
  int failures = 0;
  exp_t sb[$];
  logic [31:0] pc_ctr = 32'h1000;
  int alu_tbl [8] = '{0, 6, 8, 8, 5, 7, 4, 3};
  int br_tbl  [8] = '{10, 11, 0, 0, 13, 12, 13, 12};
  logic [6:0] opc_tbl [9] = '{7'h37, 7'h17, 7'h13, 7'h03, 7'h23, 7'h33, 7'h63, 7'h6F, 7'h67};

  // Reference: RV32I (plus M when enabled) semantics written per instruction class
  function automatic exp_t model(input logic [31:0] w, input logic [31:0] pc);
    exp_t e;
    int op, f3, f7, v;
    bit ok;
    op = int'(w[6:0]); f3 = int'(w[14:12]); f7 = int'(w[31:25]);
    e = '0;
    e.is_signed = 1'b1;
    ok = (w[1:0] == 2'b11);
    case (op)
      'h37, 'h17: begin
        e.imm = w & 32'hFFFF_F000; e.alu_op = (op == 'h37) ? 5'd9 : 5'd0;
        e.alu_src = 1; e.reg_write = 1;
      end
      'h13: begin
        v = int'(w[31:20]); if (v >= 2048) v -= 4096; e.imm = 32'(v);
        e.alu_src = 1; e.reg_write = 1; e.alu_op = 5'(alu_tbl[f3]);
        if (f3 == 3) e.is_signed = 0;
        if (f3 == 1 && f7 != 0) ok = 0;
        if (f3 == 5) begin e.is_signed = (f7 == 32); if (f7 != 0 && f7 != 32) ok = 0; end
      end
      'h03: begin
        v = int'(w[31:20]); if (v >= 2048) v -= 4096; e.imm = 32'(v);
        e.alu_src = 1; e.mem_read = 1; e.reg_write = 1; e.mem_to_reg = 1;
        if (f3 == 3 || f3 >= 6) ok = 0;
        e.size = ((f3 % 4) == 0) ? 2'd2 : ((f3 % 4) == 1) ? 2'd1 : 2'd0;
        e.is_signed = (f3 < 4);
      end
      'h23: begin
        v = int'({w[31:25], w[11:7]}); if (v >= 2048) v -= 4096; e.imm = 32'(v);
        e.alu_src = 1; e.mem_write = 1;
        if (f3 > 2) ok = 0; else e.size = 2'(2 - f3);
      end
      'h33: begin
        e.reg_write = 1;
        if (f7 == 0) begin e.alu_op = 5'(alu_tbl[f3]); e.is_signed = !(f3 == 3 || f3 == 5); end
        else if (f7 == 32 && f3 == 0) e.alu_op = 1;
        else if (f7 == 32 && f3 == 5) e.alu_op = 7;
`ifdef ID_MEXT_EN
        else if (f7 == 1) e.alu_op = 5'(14 + f3);
`endif
        else ok = 0;
      end
      'h63: begin
        v = int'({w[31], w[7], w[30:25], w[11:8], 1'b0}); if (v >= 4096) v -= 8192; e.imm = 32'(v);
        e.branch = 1; e.alu_op = 5'(br_tbl[f3]); e.is_signed = (f3 < 6);
        if (f3 == 2 || f3 == 3) ok = 0;
      end
      'h6F: begin
        v = int'({w[31], w[19:12], w[20], w[30:21], 1'b0}); if (v >= (1 << 20)) v -= (1 << 21);
        e.imm = 32'(v); e.alu_src = 1; e.reg_write = 1; e.mem_to_reg = 2; e.jump = 1;
      end
      'h67: begin
        v = int'(w[31:20]); if (v >= 2048) v -= 4096; e.imm = 32'(v);
        e.alu_src = 1; e.reg_write = 1; e.mem_to_reg = 2; e.jump = 2;
        if (f3 != 0) ok = 0;
      end
      default: ok = 0;
    endcase
    if (!ok) begin e = '0; e.illegal = 1; end
    e.pc = pc; e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.rd = w[11:7];
    return e;
  endfunction

  function automatic exp_t observed();
    exp_t o;
    o.pc = id_pc; o.rs1 = id_rs1; o.rs2 = id_rs2; o.rd = id_rd; o.imm = id_imm;
    o.alu_op = id_alu_op; o.alu_src = id_alu_src; o.mem_read = id_mem_read;
    o.mem_write = id_mem_write; o.reg_write = id_reg_write; o.branch = id_branch;
    o.mem_to_reg = id_mem_to_reg; o.jump = id_jump; o.size = id_inst_size;
    o.is_signed = id_is_signed; o.illegal = id_illegal;
    return o;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    int k;
    w = $urandom;
    k = $urandom_range(0, 10);
    if (k < 9) w[6:0] = opc_tbl[k];
    case ($urandom_range(0, 3))
      0: w[31:25] = 7'h00;
      1: w[31:25] = 7'h20;
      2: w[31:25] = 7'h01;
      default: ;
    endcase
    return w;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // One cycle of stimulus; the expected bundle is queued when the fetch transfer is seen
  task automatic step(input bit v, input logic [31:0] w, input bit rdy, input bit fl);
    @(posedge clk); #1;
    if_valid = v; if_inst = w; if_pc = pc_ctr; id_ready = rdy; flush = fl;
    @(negedge clk); #2;
    if (fl) sb.delete();
    else if (reset && if_valid && if_ready) sb.push_back(model(if_inst, if_pc));
    if (if_valid && if_ready) pc_ctr += 4;
  endtask

  // Monitor: occupancy-derived handshake checks, stall stability, and in-order scoreboard pops
  exp_t held;
  bit   stall_prev = 0;
  always @(negedge clk) begin
    exp_t o, e;
    if (reset) begin
      o = observed();
      checks++;
      if (id_valid !== (sb.size() > 0)) begin
        failures++; $display("FAIL id_valid actual=%b expected=%b", id_valid, sb.size() > 0);
      end
      checks++;
      if (if_ready !== (sb.size() <= QDEPTH)) begin
        failures++; $display("FAIL if_ready actual=%b expected=%b", if_ready, sb.size() <= QDEPTH);
      end
      if (stall_prev) begin
        checks++;
        if (id_valid !== 1'b1 || o !== held) begin
          failures++; $display("FAIL stall_stable actual=%h expected=%h", o, held);
        end
      end
      if (id_valid && id_ready) begin
        checks++;
        if (sb.size() == 0) begin
          failures++; $display("FAIL unexpected_output actual=%h expected=none", o);
        end else begin
          e = sb.pop_front();
          if (o !== e) begin
            failures++; $display("FAIL scoreboard actual=%h expected=%h", o, e);
          end
        end
      end
      stall_prev = id_valid && !id_ready && !flush;
      held = o;
    end else begin
      stall_prev = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_id_valid", {31'b0, id_valid}, 0);
    chk("rst_bundle_zero", {31'b0, (observed() != '0)}, 0);
    reset = 1'b1;

    // ADDI x5,x1,-3 bypassed straight into the output register
    step(1, 32'hFFD08293, 1, 0);
    step(0, 0, 1, 0);
    chk("addi_valid", {31'b0, id_valid}, 1);
    chk("addi_alu_op", {27'b0, id_alu_op}, 0);
    chk("addi_alu_src", {31'b0, id_alu_src}, 1);
    chk("addi_rd", {27'b0, id_rd}, 5);
    chk("addi_rs1", {27'b0, id_rs1}, 1);
    chk("addi_imm", id_imm, 32'hFFFFFFFD);
    chk("addi_reg_write", {31'b0, id_reg_write}, 1);

    // Stall: fill output register and queue, fourth offer refused
    step(1, 32'h00100093, 0, 0);
    step(1, 32'h00208113, 0, 0);
    step(1, 32'h00310193, 0, 0);
    step(1, 32'h00418213, 0, 0);
    chk("full_if_ready", {31'b0, if_ready}, 0);
    step(1, 32'h00418213, 0, 0);
    repeat (5) step(0, 0, 1, 0);

    // Flush with queue full and a fetch offer pending
    step(1, 32'h00100093, 0, 0);
    step(1, 32'h00208113, 0, 0);
    step(1, 32'h00310193, 0, 0);
    step(1, 32'h00520293, 0, 1);
    step(0, 0, 1, 0);
    chk("flush_id_valid", {31'b0, id_valid}, 0);
    chk("flush_if_ready", {31'b0, if_ready}, 1);

    // MUL: decoded only with M-extension
    step(1, 32'h02208033, 1, 0);
    step(0, 0, 1, 0);
`ifdef ID_MEXT_EN
    chk("mul_alu_op", {27'b0, id_alu_op}, 14);
    chk("mul_illegal", {31'b0, id_illegal}, 0);
`else
    chk("mul_illegal", {31'b0, id_illegal}, 1);
    chk("mul_enables", {26'b0, id_reg_write, id_mem_read, id_mem_write, id_branch, id_jump}, 0);
`endif

    // BLTU and LHU
    step(1, 32'h0020E463, 1, 0);
    step(1, 32'h00415183, 1, 0);
    chk("bltu_branch", {31'b0, id_branch}, 1);
    chk("bltu_alu_op", {27'b0, id_alu_op}, 13);
    chk("bltu_signed", {31'b0, id_is_signed}, 0);
    chk("bltu_imm", id_imm, 8);
    step(0, 0, 1, 0);
    chk("lhu_mem_read", {31'b0, id_mem_read}, 1);
    chk("lhu_mem_to_reg", {30'b0, id_mem_to_reg}, 1);
    chk("lhu_size", {30'b0, id_inst_size}, 1);
    chk("lhu_signed", {31'b0, id_is_signed}, 0);

    // Randomised traffic with back-pressure and occasional flushes
    for (int i = 0; i < 600; i++) begin
      bit fl;
      fl = ($urandom_range(0, 39) == 0);
      step($urandom_range(0, 3) != 0, rand_inst(), fl ? 1'b0 : ($urandom_range(0, 2) != 0), fl);
    end

    // Asynchronous reset with two entries queued
    step(1, 32'h00100093, 0, 0);
    step(1, 32'h00208113, 0, 0);
    step(1, 32'h00310193, 0, 0);
    @(posedge clk); #1;
    if_valid = 0; reset = 1'b0;
    #1;
    chk("midrst_id_valid", {31'b0, id_valid}, 0);
    sb.delete();
    step(0, 0, 0, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    step(0, 0, 0, 0);
    chk("midrst_if_ready", {31'b0, if_ready}, 1);
    chk("midrst_empty", {31'b0, id_valid}, 0);

    // Drain with a bounded cycle budget
    for (int i = 0; i < 50 && sb.size() != 0; i++) step(0, 0, 1, 0);
    chk("drain_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
